mac_array_engine: RTL and testbench
===================================

MAC_ARRAY_ENGINE -- requirements
Module: mac_array_engine

Interface
REQ-001 Parameter NUM_CH, default 4: number of parallel MAC lanes (output channels).
REQ-002 Parameter VEC_LEN, default 4: input samples per dot product.
REQ-003 Parameter X_W, default 8: unsigned input sample width.
REQ-004 Parameter A_W, default 14: signed two's-complement coefficient width.
REQ-005 Parameter ACC_W, default 18: signed accumulator and result width.
REQ-006 Parameter ADDR_W, default 8: write-port address width.
REQ-007 The block SHALL use one clock, clk; reset is rst, synchronous and active-high.
REQ-008 The ports SHALL be as follows (name, direction, width, meaning):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin one job; sampled only in IDLE
- sat_en  in  1  saturating accumulate when 1, wrap when 0; latched at start
- base_addr  in  ADDR_W  first write address; latched at start
- x_valid  in  1  x_data valid
- x_ready  out  1  block accepts x_data
- x_data  in  X_W  input sample
- coef_addr  out  clog2(VEC_LEN)  coefficient column index
- coef_data  in  NUM_CH*A_W  column coefficients, lane 0 in the LSBs; 1-cycle read latency
- wr_en_n  out  1  active-low write request
- wr_ry  in  1  memory ready; a write is accepted when wr_en_n=0 and wr_ry=1
- wr_addr  out  ADDR_W  write address
- wr_data  out  ACC_W  result of the current lane
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when the job completes

Function
REQ-009 The FSM SHALL have the states IDLE, LOAD, MAC, WRITE and DONE.
REQ-010 IDLE->LOAD SHALL occur on start=1; start SHALL be ignored in every other state.
REQ-011 In LOAD, x_ready SHALL be 1, and each cycle with x_valid=1 SHALL store x_data into slot k=0..VEC_LEN-1.
REQ-012 After the VEC_LEN-th accepted sample, the FSM SHALL enter MAC and x_ready SHALL drop on the next cycle.
REQ-013 On MAC entry, all lane accumulators SHALL clear to 0.
REQ-014 MAC SHALL issue coef_addr=k on MAC cycle k (k=0..VEC_LEN-1) and SHALL accumulate acc[c] += x[k]*coef[c] on cycle k+1.
REQ-015 MAC SHALL therefore last exactly VEC_LEN+1 cycles, then transition to WRITE.
REQ-016 Each product SHALL be computed as zero-extended x times a signed coefficient, sign-extended to ACC_W before the add.
REQ-017 With sat_en=0, accumulation SHALL wrap modulo 2^ACC_W.
REQ-018 With sat_en=1, each add SHALL clamp to the range [-2^(ACC_W-1), 2^(ACC_W-1)-1].
REQ-019 In WRITE, wr_en_n SHALL be 0, with wr_data=acc[lane] and wr_addr=base_addr+lane for lane=0..NUM_CH-1.
REQ-020 lane SHALL advance only on an accepted write; while wr_ry=0, wr_en_n, wr_addr and wr_data SHALL hold stable.
REQ-021 wr_addr SHALL wrap modulo 2^ADDR_W.
REQ-022 After the last accepted write, the FSM SHALL go to DONE; done SHALL be 1 for that one cycle, then the FSM SHALL return to IDLE.
REQ-023 Outside WRITE, wr_en_n SHALL be 1.
REQ-024 x_valid=1 while x_ready=0 SHALL be ignored, with no state change.

Reset
REQ-025 On rst=1, at the next clk edge and from any state, the block SHALL enter IDLE.
REQ-026 On that reset, the following SHALL be set: x_ready=0, wr_en_n=1, busy=0, done=0, coef_addr=0, wr_addr=0, wr_data=0.
REQ-027 On that reset, the sample slots, accumulators and counters SHALL clear to 0.
REQ-028 rst SHALL take priority over all other inputs, and an aborted job SHALL issue no further writes.

Structure
REQ-029 The FSM state enum and the saturating-add function SHALL live in the shared package mac_pkg.
REQ-030 One sub-module, mac_lane (single accumulator with wrap or saturate mode), SHALL be instantiated NUM_CH times via generate.

Verification
REQ-031 Defaults, sat_en=0, base_addr=0x10, X=1,2,3,4, all coefficients=1 -> writes of 10 to 0x10..0x13, then a one-cycle done pulse.
REQ-032 X=255 x4, all coefficients=8191: sat_en=1 -> every result is 131071; sat_en=0 -> every result is -33788 (wrap).
REQ-033 Coefficients lane c = -(c+1), X=1,1,1,1 -> results -4, -8, -12, -16.
REQ-034 wr_ry held 0 for 3 cycles during the lane-2 write -> wr_addr, wr_data and wr_en_n stay stable, with exactly 4 writes total and no duplicates.
REQ-035 rst asserted mid-MAC -> IDLE next cycle, wr_en_n=1, no writes; a fresh job afterwards yields the correct results.
REQ-036 start pulsed during LOAD, and x_valid gaps between samples -> the job is unaffected and the results are correct.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types and helpers for the MAC array engine.
package mac_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_MAC   = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Signed add clamped to the range of an i_w-bit two's-complement value.
  // Operands are pre-extended to 64 bits so the true sum is always visible.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] i_a,
                                                 input logic signed [63:0] i_b,
                                                 input int unsigned       i_w);
    logic signed [63:0] sum;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sum = i_a + i_b;
    hi  = (64'sd1 <<< (i_w - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (i_w - 1));
    if (sum > hi) return hi;
    if (sum < lo) return lo;
    return sum;
  endfunction

endpackage

// File: rtl/mac_lane.sv
// One MAC lane: accumulates unsigned sample times signed coefficient,
// either wrapping or saturating at the accumulator width.
module mac_lane
  import mac_pkg::*;
#(
  parameter int unsigned X_W   = 8,
  parameter int unsigned A_W   = 14,
  parameter int unsigned ACC_W = 18
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_clr,
  input  logic                    i_en,
  input  logic                    i_sat,
  input  logic [X_W-1:0]          i_x,
  input  logic signed [A_W-1:0]   i_coef,
  output logic signed [ACC_W-1:0] o_acc
);

  localparam int unsigned P_W = X_W + A_W + 1;

  logic signed [P_W-1:0]   w_prod;
  logic signed [ACC_W-1:0] w_wrap;
  logic signed [ACC_W-1:0] w_sat;
  logic signed [ACC_W-1:0] r_acc;

  // Full-precision product; saturation must see it untruncated.
  always_comb begin
    w_prod = P_W'($signed({1'b0, i_x})) * P_W'(i_coef);
    w_wrap = r_acc + ACC_W'(w_prod);
    w_sat  = ACC_W'(sat_add(64'(r_acc), 64'(w_prod), ACC_W));
  end

  // Accumulator register: clear has priority over accumulate.
  always_ff @(posedge clk) begin
    if (rst)        r_acc <= '0;
    else if (i_clr) r_acc <= '0;
    else if (i_en)  r_acc <= i_sat ? w_sat : w_wrap;
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/mac_array_engine.sv
// Loads a sample vector, runs NUM_CH parallel dot products against a
// column-addressed coefficient memory, then writes one result per lane.
module mac_array_engine
  import mac_pkg::*;
#(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned VEC_LEN = 4,
  parameter int unsigned X_W     = 8,
  parameter int unsigned A_W     = 14,
  parameter int unsigned ACC_W   = 18,
  parameter int unsigned ADDR_W  = 8,
  localparam int unsigned CA_W   = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  sat_en,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic                  x_valid,
  output logic                  x_ready,
  input  logic [X_W-1:0]        x_data,
  output logic [CA_W-1:0]       coef_addr,
  input  logic [NUM_CH*A_W-1:0] coef_data,
  output logic                  wr_en_n,
  input  logic                  wr_ry,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [ACC_W-1:0]      wr_data,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned K_W = $clog2(VEC_LEN + 1);
  localparam int unsigned L_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  state_e              r_state, w_state_nx;
  logic [X_W-1:0]      r_x [VEC_LEN];
  logic [K_W-1:0]      r_k;
  logic [L_W-1:0]      r_lane;
  logic                r_sat;
  logic [ADDR_W-1:0]   r_base;

  logic                w_in_load, w_in_mac, w_in_write;
  logic                w_last_k, w_mac_end, w_last_lane, w_wr_acc;
  logic                w_clr, w_en;
  logic [K_W-1:0]      w_xi;
  logic [X_W-1:0]      w_x_sel;
  logic signed [ACC_W-1:0] w_acc [NUM_CH];

  // Decoded state and counter conditions; sample for MAC cycle k is x[k-1].
  always_comb begin
    w_in_load   = (r_state == ST_LOAD);
    w_in_mac    = (r_state == ST_MAC);
    w_in_write  = (r_state == ST_WRITE);
    w_last_k    = (r_k == K_W'(VEC_LEN - 1));
    w_mac_end   = (r_k == K_W'(VEC_LEN));
    w_last_lane = (r_lane == L_W'(NUM_CH - 1));
    w_wr_acc    = w_in_write && wr_ry;
    w_clr       = w_in_mac && (r_k == '0);
    w_en        = w_in_mac && (r_k != '0);
    w_xi        = r_k - K_W'(1);
    w_x_sel     = '0;
    for (int i = 0; i < int'(VEC_LEN); i++) begin
      if (w_xi == K_W'(i)) w_x_sel = r_x[i];
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_state_nx = ST_LOAD;
      ST_LOAD:  if (x_valid && w_last_k) w_state_nx = ST_MAC;
      ST_MAC:   if (w_mac_end) w_state_nx = ST_WRITE;
      ST_WRITE: if (w_wr_acc && w_last_lane) w_state_nx = ST_DONE;
      ST_DONE:  w_state_nx = ST_IDLE;
      default:  w_state_nx = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nx;
  end

  // Job parameters, sample slots, cycle counter and write lane.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_k    <= '0;
      r_lane <= '0;
      r_sat  <= 1'b0;
      r_base <= '0;
      for (int i = 0; i < int'(VEC_LEN); i++) r_x[i] <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (start) begin
          r_sat  <= sat_en;
          r_base <= base_addr;
          r_k    <= '0;
          r_lane <= '0;
        end
        ST_LOAD: if (x_valid) begin
          for (int i = 0; i < int'(VEC_LEN); i++) begin
            if (r_k == K_W'(i)) r_x[i] <= x_data;
          end
          r_k <= w_last_k ? '0 : r_k + K_W'(1);
        end
        ST_MAC: begin
          r_k    <= w_mac_end ? '0 : r_k + K_W'(1);
          r_lane <= '0;
        end
        ST_WRITE: if (wr_ry) r_lane <= w_last_lane ? '0 : r_lane + L_W'(1);
        default: ;
      endcase
    end
  end

  for (genvar c = 0; c < int'(NUM_CH); c++) begin : g_lane
    mac_lane #(
      .X_W   (X_W),
      .A_W   (A_W),
      .ACC_W (ACC_W)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .i_clr  (w_clr),
      .i_en   (w_en),
      .i_sat  (r_sat),
      .i_x    (w_x_sel),
      .i_coef (coef_data[c*A_W +: A_W]),
      .o_acc  (w_acc[c])
    );
  end

  // Outputs are gated by state so they read zero whenever idle or in reset.
  always_comb begin
    x_ready   = w_in_load;
    busy      = (r_state != ST_IDLE);
    done      = (r_state == ST_DONE);
    wr_en_n   = !w_in_write;
    coef_addr = (w_in_mac && (r_k < K_W'(VEC_LEN))) ? CA_W'(r_k) : '0;
    wr_addr   = w_in_write ? (r_base + ADDR_W'(r_lane)) : '0;
    wr_data   = '0;
    for (int c = 0; c < int'(NUM_CH); c++) begin
      if (w_in_write && (r_lane == L_W'(c))) wr_data = w_acc[c];
    end
  end

endmodule

// File: tb/tb_mac_array_engine.sv
// Self-checking bench for mac_array_engine: directed and randomized jobs
// checked against a plain-arithmetic dot-product model.
module tb_mac_array_engine;

  localparam int NUM_CH  = 4;
  localparam int VEC_LEN = 4;
  localparam int X_W     = 8;
  localparam int A_W     = 14;
  localparam int ACC_W   = 18;
  localparam int ADDR_W  = 8;
  localparam int CA_W    = 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  start = 1'b0;
  logic                  sat_en = 1'b0;
  logic [ADDR_W-1:0]     base_addr = '0;
  logic                  x_valid = 1'b0;
  logic                  x_ready;
  logic [X_W-1:0]        x_data = '0;
  logic [CA_W-1:0]       coef_addr;
  logic [NUM_CH*A_W-1:0] coef_data = '0;
  logic                  wr_en_n;
  logic                  wr_ry = 1'b1;
  logic [ADDR_W-1:0]     wr_addr;
  logic [ACC_W-1:0]      wr_data;
  logic                  busy;
  logic                  done;

  int checks = 0;
  int errors = 0;

  int x_mem [VEC_LEN];
  int coef_mem [VEC_LEN][NUM_CH];
  logic [ADDR_W-1:0] wa_q [$];
  logic [ACC_W-1:0]  wd_q [$];
  int done_cnt = 0;

  mac_array_engine #(
    .NUM_CH  (NUM_CH),
    .VEC_LEN (VEC_LEN),
    .X_W     (X_W),
    .A_W     (A_W),
    .ACC_W   (ACC_W),
    .ADDR_W  (ADDR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sat_en    (sat_en),
    .base_addr (base_addr),
    .x_valid   (x_valid),
    .x_ready   (x_ready),
    .x_data    (x_data),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .wr_en_n   (wr_en_n),
    .wr_ry     (wr_ry),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  function automatic logic [NUM_CH*A_W-1:0] pack_col(input logic [CA_W-1:0] k);
    logic [NUM_CH*A_W-1:0] r;
    r = '0;
    for (int c = 0; c < NUM_CH; c++) r[c*A_W +: A_W] = A_W'(coef_mem[k][c]);
    return r;
  endfunction

  // Coefficient memory with one cycle of read latency.
  always @(posedge clk) coef_data <= pack_col(coef_addr);

  // Write-port and done observer, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (!wr_en_n && wr_ry) begin
        wa_q.push_back(wr_addr);
        wd_q.push_back(wr_data);
      end
      if (done) done_cnt++;
    end
  end

  // Reference: exact dot product, then wrap or per-step clamp.
  function automatic longint expect_lane(input int c, input bit sat);
    longint acc, hi, lo, m;
    hi  = (longint'(1) <<< (ACC_W - 1)) - 1;
    lo  = -(longint'(1) <<< (ACC_W - 1));
    m   = longint'(1) <<< ACC_W;
    acc = 0;
    for (int k = 0; k < VEC_LEN; k++) begin
      acc = acc + longint'(x_mem[k]) * longint'(coef_mem[k][c]);
      if (sat) begin
        if (acc > hi) acc = hi;
        if (acc < lo) acc = lo;
      end else begin
        acc = ((acc % m) + m) % m;
        if (acc > hi) acc = acc - m;
      end
    end
    return acc;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_job();
    for (int k = 0; k < VEC_LEN; k++) begin
      x_mem[k] = int'($urandom_range(0, 255));
      for (int c = 0; c < NUM_CH; c++) coef_mem[k][c] = int'($urandom_range(0, 16383)) - 8192;
    end
  endtask

  task automatic start_job(input bit sat, input logic [ADDR_W-1:0] base);
    wa_q.delete();
    wd_q.delete();
    done_cnt  = 0;
    start     = 1'b1;
    sat_en    = sat;
    base_addr = base;
    tick();
    start     = 1'b0;
    sat_en    = !sat;
    base_addr = ~base;
  endtask

  task automatic feed(input int gap_max, input bit poke);
    for (int k = 0; k < VEC_LEN; k++) begin
      int gaps;
      int n;
      gaps = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      repeat (gaps) begin
        x_valid = 1'b0;
        x_data  = X_W'($urandom);
        start   = poke;
        tick();
        start   = 1'b0;
      end
      x_valid = 1'b1;
      x_data  = X_W'(x_mem[k]);
      n = 0;
      while (!x_ready && n < 20) begin
        tick();
        n++;
      end
      if (!x_ready) begin
        checks++;
        errors++;
        $display("FAIL feed_timeout: x_ready=%b required 1 at sample %0d", x_ready, k);
      end
      tick();
      x_valid = 1'b0;
    end
  endtask

  task automatic drain(input string tag, input bit sat, input logic [ADDR_W-1:0] base,
                       input int stall_lane, input int stall_len, input bit rand_ry,
                       input bit junk_x);
    int held;
    bit seen;
    logic [ADDR_W-1:0] h_addr;
    logic [ACC_W-1:0]  h_data;
    held = 0;
    seen = 1'b0;
    h_addr = '0;
    h_data = '0;
    for (int cyc = 0; cyc < 120 && !seen; cyc++) begin
      if (junk_x) begin
        x_valid = 1'b1;
        x_data  = X_W'($urandom);
      end
      if (held > 0 && wa_q.size() == stall_lane) begin
        checks++;
        if (wr_addr !== h_addr || wr_data !== h_data || wr_en_n !== 1'b0) begin
          errors++;
          $display("FAIL %s stall_hold: en_n=%b addr=%h data=%h required en_n=0 addr=%h data=%h",
                   tag, wr_en_n, wr_addr, wr_data, h_addr, h_data);
        end
      end
      if (!wr_en_n && wa_q.size() == stall_lane && held < stall_len) begin
        if (held == 0) begin
          h_addr = wr_addr;
          h_data = wr_data;
        end
        wr_ry = 1'b0;
        held++;
      end else begin
        wr_ry = rand_ry ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
      if (done) seen = 1'b1;
      tick();
    end
    wr_ry   = 1'b1;
    x_valid = 1'b0;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s done_timeout: done never seen, required one pulse", tag);
    end
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s after_done: done=%b busy=%b required done=0 busy=0", tag, done, busy);
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL %s done_pulses: got %0d required 1", tag, done_cnt);
    end
    checks++;
    if (wa_q.size() != NUM_CH) begin
      errors++;
      $display("FAIL %s write_count: got %0d required %0d", tag, wa_q.size(), NUM_CH);
    end
    for (int i = 0; i < NUM_CH && i < wa_q.size(); i++) begin
      logic [ADDR_W-1:0] ea;
      longint ed, gd;
      ea = base + ADDR_W'(i);
      ed = expect_lane(i, sat);
      gd = longint'($signed(wd_q[i]));
      checks++;
      if (wa_q[i] !== ea || gd != ed) begin
        errors++;
        $display("FAIL %s lane%0d: addr=%h data=%0d required addr=%h data=%0d",
                 tag, i, wa_q[i], gd, ea, ed);
      end
    end
  endtask

  task automatic run_job(input string tag, input bit sat, input logic [ADDR_W-1:0] base,
                         input int gap_max, input bit poke, input int stall_lane,
                         input int stall_len, input bit rand_ry, input bit junk_x);
    start_job(sat, base);
    feed(gap_max, poke);
    drain(tag, sat, base, stall_lane, stall_len, rand_ry, junk_x);
  endtask

  task automatic test_reset();
    start = 1'b1;
    x_valid = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    start = 1'b0;
    x_valid = 1'b0;
    checks++;
    if (x_ready !== 1'b0 || wr_en_n !== 1'b1 || busy !== 1'b0 || done !== 1'b0 ||
        coef_addr !== '0 || wr_addr !== '0 || wr_data !== '0) begin
      errors++;
      $display("FAIL reset_outputs: x_ready=%b wr_en_n=%b busy=%b done=%b ca=%h wa=%h wd=%h required 0 1 0 0 0 0 0",
               x_ready, wr_en_n, busy, done, coef_addr, wr_addr, wr_data);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b required 0", busy);
    end
  endtask

  task automatic test_basic();
    for (int k = 0; k < VEC_LEN; k++) begin
      x_mem[k] = k + 1;
      for (int c = 0; c < NUM_CH; c++) coef_mem[k][c] = 1;
    end
    run_job("basic", 1'b0, 8'h10, 0, 1'b0, -1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_saturate();
    for (int k = 0; k < VEC_LEN; k++) begin
      x_mem[k] = 255;
      for (int c = 0; c < NUM_CH; c++) coef_mem[k][c] = 8191;
    end
    run_job("sat_on", 1'b1, 8'h20, 0, 1'b0, -1, 0, 1'b0, 1'b0);
    run_job("sat_off", 1'b0, 8'h30, 0, 1'b0, -1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_negative();
    for (int k = 0; k < VEC_LEN; k++) begin
      x_mem[k] = 1;
      for (int c = 0; c < NUM_CH; c++) coef_mem[k][c] = -(c + 1);
    end
    run_job("negative", 1'b0, 8'h40, 0, 1'b0, -1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_stall();
    randomize_job();
    run_job("stall", 1'b0, 8'h50, 0, 1'b0, 2, 3, 1'b0, 1'b0);
  endtask

  task automatic test_abort();
    randomize_job();
    start_job(1'b0, 8'h60);
    feed(0, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || wr_en_n !== 1'b1 || x_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: busy=%b wr_en_n=%b x_ready=%b required 0 1 0",
               busy, wr_en_n, x_ready);
    end
    repeat (20) tick();
    checks++;
    if (wa_q.size() != 0 || done_cnt != 0) begin
      errors++;
      $display("FAIL abort_no_writes: writes=%0d done=%0d required 0 0", wa_q.size(), done_cnt);
    end
    randomize_job();
    run_job("after_abort", 1'b1, 8'h70, 0, 1'b0, -1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_gaps_start();
    randomize_job();
    run_job("gaps_start", 1'b0, 8'h80, 3, 1'b1, -1, 0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    for (int j = 0; j < 8; j++) begin
      logic [ADDR_W-1:0] b;
      randomize_job();
      b = (j == 0) ? 8'hFE : ADDR_W'($urandom);
      run_job("random", 1'($urandom), b, 2, 1'b0, -1, 0, 1'b1, 1'b0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_negative();
    test_stall();
    test_abort();
    test_gaps_start();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
